// File: rtl/boot_pkg.sv
// boot_pkg: shared types and sizes for the boot PROM copier.
// Holds the copier state enum and the PROM/RAM address widths.
package boot_pkg;

    localparam int PROM_AW        = 9;
    localparam int RAM_AW         = 22;
    localparam int PROM_MAX_WORDS = 512;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/boot_sum.sv
// boot_sum: 32-bit modulo-2^32 checksum accumulator for the copier.
// Ports: clk, rst (sync, active-high), clr, add_en, data[31:0] in; zero out.
module boot_sum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_en,
    input  logic [31:0] data,
    output logic        zero
);

    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

    assign zero = (sum == 32'd0);

endmodule

// File: rtl/boot_copier.sv
// boot_copier: copies WORDS PROM words into RAM at RAM_BASE after start.
// Ports: clk, rst, start in; busy, done, err out; PROM stb/we/addr/data/ack;
// RAM stb/we/addr/wdata/ack. Optional checksum: define BOOT_CHECKSUM_EN.
module boot_copier
    import boot_pkg::*;
#(
    parameter int                 WORDS    = 512,
    parameter logic [RAM_AW-1:0]  RAM_BASE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               prom_stb,
    output logic               prom_we,
    output logic [PROM_AW-1:0] prom_addr,
    input  logic [31:0]        prom_data,
    input  logic               prom_ack,
    output logic               ram_stb,
    output logic               ram_we,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic               ram_ack
);

    localparam logic [PROM_AW-1:0] LAST = PROM_AW'(WORDS - 1);

    state_t              state, state_n;
    logic                busy_n, done_n;
    logic                prom_stb_n, ram_stb_n;
    logic [PROM_AW-1:0]  idx_n;
    logic [RAM_AW-1:0]   ram_addr_n;
    logic [31:0]         ram_wdata_n;

`ifdef BOOT_CHECKSUM_EN
    logic sum_clr, sum_add, sum_zero;
    logic err_q, err_n;

    boot_sum u_sum (
        .clk    (clk),
        .rst    (rst),
        .clr    (sum_clr),
        .add_en (sum_add),
        .data   (prom_data),
        .zero   (sum_zero)
    );

    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_n;
    end
`else
    assign err = 1'b0;
`endif

    assign prom_we = 1'b0;
    assign ram_we  = ram_stb;

    // prom_addr doubles as the word index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            prom_stb  <= 1'b0;
            ram_stb   <= 1'b0;
            prom_addr <= '0;
            ram_addr  <= RAM_BASE;
            ram_wdata <= '0;
        end else begin
            state     <= state_n;
            busy      <= busy_n;
            done      <= done_n;
            prom_stb  <= prom_stb_n;
            ram_stb   <= ram_stb_n;
            prom_addr <= idx_n;
            ram_addr  <= ram_addr_n;
            ram_wdata <= ram_wdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        busy_n      = busy;
        done_n      = done;
        prom_stb_n  = prom_stb;
        ram_stb_n   = ram_stb;
        idx_n       = prom_addr;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
`ifdef BOOT_CHECKSUM_EN
        sum_clr     = 1'b0;
        sum_add     = 1'b0;
        err_n       = err_q;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = RD;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    prom_stb_n = 1'b1;
                    idx_n      = '0;
`ifdef BOOT_CHECKSUM_EN
                    sum_clr    = 1'b1;
                    err_n      = 1'b0;
`endif
                end
            end
            RD: begin
                // Strobe drops in the same edge that consumes the ack.
                if (prom_stb && prom_ack) begin
                    state_n     = WR;
                    prom_stb_n  = 1'b0;
                    ram_stb_n   = 1'b1;
                    ram_wdata_n = prom_data;
                    ram_addr_n  = RAM_BASE + RAM_AW'(prom_addr);
`ifdef BOOT_CHECKSUM_EN
                    sum_add     = 1'b1;
`endif
                end
            end
            WR: begin
                if (ram_stb && ram_ack) begin
                    ram_stb_n = 1'b0;
                    if (prom_addr == LAST) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        // Sum already holds the last word here.
                        err_n   = ~sum_zero;
`endif
                    end else begin
                        state_n    = RD;
                        prom_stb_n = 1'b1;
                        idx_n      = prom_addr + 9'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: directed, table-driven bench for boot_copier.
// Models a toggling-ack PROM and a variable-latency RAM responder.
module tb_boot_copier;

    localparam int          W    = 4;
    localparam logic [21:0] BASE = 22'h3FFFFE;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        prom_stb, prom_we;
    logic [8:0]  prom_addr;
    logic [31:0] prom_data = '0;
    logic        prom_ack = 1'b0;
    logic        ram_stb, ram_we;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_ack = 1'b0;

    boot_copier #(.WORDS(W), .RAM_BASE(BASE)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .prom_stb  (prom_stb),
        .prom_we   (prom_we),
        .prom_addr (prom_addr),
        .prom_data (prom_data),
        .prom_ack  (prom_ack),
        .ram_stb   (ram_stb),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ack   (ram_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] prom_mem [4];
    int          ram_lat = 1;
    int          cnt = 0;

    always @(posedge clk) begin
        prom_ack  <= prom_stb & ~prom_ack;
        prom_data <= prom_mem[prom_addr[1:0]];
    end

    always @(posedge clk) begin
        if (!ram_stb || ram_ack) begin
            cnt     <= 0;
            ram_ack <= 1'b0;
        end else if (cnt >= ram_lat - 1) begin
            ram_ack <= 1'b1;
        end else begin
            cnt <= cnt + 1;
        end
    end

    logic [21:0] wq_a [$];
    logic [31:0] wq_d [$];
    int          excl = 0;
    int          stab = 0;
    bit          hold = 1'b0;
    logic [21:0] pa;
    logic [31:0] pd;

    always @(negedge clk) begin
        if (prom_stb && ram_stb) excl++;
        if (prom_we || (ram_we != ram_stb)) excl++;
        if (hold && ram_stb && (ram_addr != pa || ram_wdata != pd)) stab++;
        hold = ram_stb && !ram_ack;
        pa   = ram_addr;
        pd   = ram_wdata;
        if (ram_stb && ram_ack) begin
            wq_a.push_back(ram_addr);
            wq_d.push_back(ram_wdata);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string n, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][31:0] w;
        int               lat;
        bit               exp_err;
        int               exp_cyc;
        int               extra;
    } vec_t;

    vec_t vt [5];

    task automatic run_vec(input vec_t v, input string tag);
        int          k;
        logic [21:0] ea;
        for (int i = 0; i < 4; i++) prom_mem[i] = v.w[i];
        ram_lat = v.lat;
        wq_a.delete();
        wq_d.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_go"}, 128'({busy, prom_stb, done}), 128'(3'b110));
        k = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = c;
                break;
            end
            start = (c == v.extra);
        end
        start = 1'b0;
        check({tag, "_cyc"}, 128'(k), 128'(v.exp_cyc));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(v.exp_err));
        check({tag, "_nwr"}, 128'(wq_a.size()), 128'(4));
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            ea = BASE + 22'(i);
            check($sformatf("%s_a%0d", tag, i), 128'(wq_a[i]), 128'(ea));
            check($sformatf("%s_d%0d", tag, i), 128'(wq_d[i]), 128'(v.w[i]));
        end
    endtask

    initial begin
        int t;
        vt[0] = '{w: {32'hFFFFFFFA, 32'd3, 32'd2, 32'd1},
                  lat: 1, exp_err: 1'b0, exp_cyc: 16, extra: 0};
        vt[1] = '{w: {32'hFFFFFFFB, 32'd3, 32'd2, 32'd1},
                  lat: 1, exp_err: CK, exp_cyc: 16, extra: 0};
        vt[2] = '{w: {32'hFFFFFFC4, 32'd30, 32'd20, 32'd10},
                  lat: 3, exp_err: 1'b0, exp_cyc: 24, extra: 0};
        vt[3] = '{w: {32'd0, 32'd0, 32'd0, 32'hDEADBEEF},
                  lat: 3, exp_err: CK, exp_cyc: 24, extra: 0};
        vt[4] = '{w: {32'hFFFFFFFA, 32'd3, 32'd2, 32'd1},
                  lat: 1, exp_err: 1'b0, exp_cyc: 16, extra: 5};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", c),
                  128'({busy, done, err, prom_stb, ram_stb, prom_we,
                        ram_we, prom_addr, ram_addr, ram_wdata}),
                  128'({7'b0, 9'd0, BASE, 32'd0}));
        end

        for (int r = 0; r < 5; r++) run_vec(vt[r], $sformatf("vec%0d", r));

        for (int i = 0; i < 4; i++) prom_mem[i] = vt[0].w[i];
        ram_lat = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(ram_stb && prom_addr == 9'd2) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_reach", 128'(t < 100), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst",
              128'({prom_stb, ram_stb, busy, done, prom_addr, ram_addr}),
              128'({4'b0, 9'd0, BASE}));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_idle", 128'({prom_stb, ram_stb, busy}), 128'(0));
        run_vec(vt[1], "restart");

        check("strobe_excl", 128'(excl), 128'(0));
        check("ram_stable", 128'(stab), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
